// File: rtl/ysyx_25030085_mem_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and load/store (read/write).
// One outstanding transaction; LSU has fixed priority; a response timeout forces an error reply.
module ysyx_25030085_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rsp_valid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_rsp_err,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_rsp_valid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_rsp_err,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rsp_err
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitIfu,
        StWaitLsu
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             any_req;
    logic             timeout_hit;
    logic             rsp_fire;
    logic [31:0]      rsp_data;
    logic             rsp_err;

    assign any_req     = ifu_req_valid | lsu_req_valid;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // A real response takes precedence over a coincident timeout.
    assign rsp_fire = mem_rsp_valid | timeout_hit;
    assign rsp_data = mem_rsp_valid ? mem_rdata : 32'd0;
    assign rsp_err  = mem_rsp_valid ? mem_rsp_err : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_req_valid = 1'b0;
        mem_addr      = 32'd0;
        mem_wen       = 1'b0;
        mem_wdata     = 32'd0;
        mem_wmask     = 4'd0;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rdata     = 32'd0;
        ifu_rsp_err   = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rdata     = 32'd0;
        lsu_rsp_err   = 1'b0;

        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    // Late or stray memory responses are ignored here.
                    mem_req_valid = any_req;
                    if (lsu_req_valid) begin
                        mem_addr      = lsu_addr;
                        mem_wen       = lsu_wen;
                        mem_wdata     = lsu_wdata;
                        mem_wmask     = lsu_wmask;
                        lsu_req_ready = mem_req_ready;
                    end else if (ifu_req_valid) begin
                        mem_addr      = ifu_addr;
                        ifu_req_ready = mem_req_ready;
                    end
                    if (any_req && mem_req_ready) begin
                        state_d = lsu_req_valid ? StWaitLsu : StWaitIfu;
                        cnt_d   = '0;
                    end
                end
                StWaitIfu: begin
                    if (rsp_fire) begin
                        ifu_rsp_valid = 1'b1;
                        ifu_rdata     = rsp_data;
                        ifu_rsp_err   = rsp_err;
                        state_d       = StIdle;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StWaitLsu: begin
                    if (rsp_fire) begin
                        lsu_rsp_valid = 1'b1;
                        lsu_rdata     = rsp_data;
                        lsu_rsp_err   = rsp_err;
                        state_d       = StIdle;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule
